// File: rtl/uart_sol_pkg.sv
// Shared types for the BMC serial-over-LAN UART mux sequencer: FSM states and mux path codes.
package uart_sol_pkg;

    typedef enum logic [1:0] {
        ACTIVE    = 2'b00,
        WAIT_IDLE = 2'b01,
        GAP       = 2'b10,
        SETTLE    = 2'b11
    } state_e;

    localparam logic [1:0] SOL_UART0_A = 2'b00;
    localparam logic [1:0] SOL_UART1_A = 2'b01;
    localparam logic [1:0] SOL_UART0_B = 2'b10;
    localparam logic [1:0] SOL_UART1_B = 2'b11;

endpackage

// File: rtl/gpio_debounce.sv
// Two-flop synchronizer plus stable-count debouncer for a bus of asynchronous GPIO pins.
// The output loads the synchronized value after it differs and holds still for DEBOUNCE_CYC cycles.
module gpio_debounce #(
    parameter int WIDTH        = 2,
    parameter int DEBOUNCE_CYC = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] deb_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    // Stable counter: sync1 != sync2 means sync2 is about to change, so the run restarts.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (sync1_q != sync2_q) begin
            cnt_d = '0;
        end else if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1'b1);
        end
    end

    // Synchronizer and debounce state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = deb_q;

endmodule

// File: rtl/uart_sol_ctrl.sv
// SOL UART mux sequencer: waits for idle TX lines, disables the mux for a guard gap, then retargets.
// Optional idle-wait timeout with forced switch is built when UART_SOL_CTRL_TIMEOUT_EN is defined.
module uart_sol_ctrl
    import uart_sol_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1024,
    parameter int IDLE_CYC     = 2170,
    parameter int GAP_CYC      = 64,
    parameter int TIMEOUT_CYC  = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bmc_gpio24,
    input  logic       bmc_gpio25,
    input  logic       bmc_tx,
    input  logic       host_tx,
    output logic [1:0] sol_select,
    output logic       sol_en,
    output logic       switch_busy,
    output logic       switch_done,
    output logic       switch_forced
);

    localparam int IW = $clog2(IDLE_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

    if (DEBOUNCE_CYC < 1 || IDLE_CYC < 1 || GAP_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("uart_sol_ctrl: all cycle parameters must be at least 1");
    end

    state_e          state_q, state_d;
    logic [1:0]      sol_select_q, sol_select_d;
    logic            sol_en_q, sol_en_d;
    logic            switch_busy_q, switch_busy_d;
    logic            switch_done_q, switch_done_d;
    logic            done_pend_q, done_pend_d;
    logic [1:0]      target_q, target_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [1:0]      tx_sync1_q;
    logic [1:0]      tx_sync2_q;
    logic [1:0]      deb_sel;
    logic            lines_idle;
    logic            to_gap;

`ifdef UART_SOL_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            switch_forced_q, switch_forced_d;
`endif

    gpio_debounce #(
        .WIDTH        (2),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_sel_debounce (
        .clk   (clk),
        .reset (reset),
        .din   ({bmc_gpio24, bmc_gpio25}),
        .dout  (deb_sel)
    );

    assign lines_idle = &tx_sync2_q;

    // Next-state and registered-output logic for the switch sequencer.
    always_comb begin
        state_d       = state_q;
        sol_select_d  = sol_select_q;
        sol_en_d      = sol_en_q;
        switch_busy_d = switch_busy_q;
        switch_done_d = 1'b0;
        done_pend_d   = done_pend_q;
        target_d      = target_q;
        idle_cnt_d    = idle_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        to_gap        = 1'b0;
`ifdef UART_SOL_CTRL_TIMEOUT_EN
        wait_cnt_d      = wait_cnt_q;
        switch_forced_d = 1'b0;
`endif
        case (state_q)
            ACTIVE: begin
                sol_en_d      = 1'b1;
                switch_busy_d = 1'b0;
                if (deb_sel != sol_select_q) begin
                    state_d       = WAIT_IDLE;
                    switch_busy_d = 1'b1;
                    target_d      = deb_sel;
                    idle_cnt_d    = '0;
`ifdef UART_SOL_CTRL_TIMEOUT_EN
                    wait_cnt_d    = '0;
`endif
                end else begin
                    state_d = ACTIVE;
                end
            end
            WAIT_IDLE: begin
                if (deb_sel == sol_select_q) begin
                    state_d       = ACTIVE;
                    switch_busy_d = 1'b0;
                end else begin
                    target_d = deb_sel;
                    if (lines_idle) begin
                        if (idle_cnt_q >= IDLE_LAST) begin
                            to_gap = 1'b1;
                        end else begin
                            idle_cnt_d = idle_cnt_q + IW'(1'b1);
                        end
                    end else begin
                        idle_cnt_d = '0;
                    end
`ifdef UART_SOL_CTRL_TIMEOUT_EN
                    // A natural idle completion wins over a timeout on the same edge.
                    if (to_gap) begin
                        wait_cnt_d = wait_cnt_q;
                    end else if (wait_cnt_q >= WAIT_LAST) begin
                        to_gap          = 1'b1;
                        switch_forced_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + TW'(1'b1);
                    end
`endif
                    if (to_gap) begin
                        state_d   = GAP;
                        sol_en_d  = 1'b0;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end
            end
            GAP: begin
                sol_en_d = 1'b0;
                target_d = deb_sel;
                if (gap_cnt_q >= GAP_LAST) begin
                    state_d      = SETTLE;
                    sol_select_d = target_q;
                    done_pend_d  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1'b1);
                end
            end
            SETTLE: begin
                // done_pend distinguishes a real switch from the post-reset settle.
                state_d       = ACTIVE;
                sol_en_d      = 1'b1;
                switch_busy_d = 1'b0;
                switch_done_d = done_pend_q;
                done_pend_d   = 1'b0;
            end
            default: begin
                state_d       = SETTLE;
                sol_en_d      = 1'b0;
                switch_busy_d = 1'b1;
            end
        endcase
    end

    // Sequencer state, TX-line synchronizers and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= SETTLE;
            sol_select_q  <= SOL_UART0_A;
            sol_en_q      <= 1'b0;
            switch_busy_q <= 1'b1;
            switch_done_q <= 1'b0;
            done_pend_q   <= 1'b0;
            target_q      <= SOL_UART0_A;
            idle_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            tx_sync1_q    <= 2'b00;
            tx_sync2_q    <= 2'b00;
        end else begin
            state_q       <= state_d;
            sol_select_q  <= sol_select_d;
            sol_en_q      <= sol_en_d;
            switch_busy_q <= switch_busy_d;
            switch_done_q <= switch_done_d;
            done_pend_q   <= done_pend_d;
            target_q      <= target_d;
            idle_cnt_q    <= idle_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            tx_sync1_q    <= {host_tx, bmc_tx};
            tx_sync2_q    <= tx_sync1_q;
        end
    end

`ifdef UART_SOL_CTRL_TIMEOUT_EN
    // Idle-wait timeout counter and forced-switch pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q      <= '0;
            switch_forced_q <= 1'b0;
        end else begin
            wait_cnt_q      <= wait_cnt_d;
            switch_forced_q <= switch_forced_d;
        end
    end

    assign switch_forced = switch_forced_q;
`else
    assign switch_forced = 1'b0;
`endif

    assign sol_select  = sol_select_q;
    assign sol_en      = sol_en_q;
    assign switch_busy = switch_busy_q;
    assign switch_done = switch_done_q;

endmodule

// File: tb/tb_uart_sol_ctrl.sv
// Scoreboard bench for uart_sol_ctrl: stimulus queues expected mux events, a monitor matches them.
module tb_uart_sol_ctrl;

    localparam int EV_FALL   = 0;
    localparam int EV_FORCED = 1;
    localparam int EV_DONE   = 2;
    localparam int LOW_EXP   = 3;

    typedef struct {
        int         kind;
        logic [1:0] sel;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       bmc_gpio24;
    logic       bmc_gpio25;
    logic       bmc_tx;
    logic       host_tx;
    logic [1:0] sol_select;
    logic       sol_en;
    logic       switch_busy;
    logic       switch_done;
    logic       switch_forced;

    exp_t       exp_q[$];
    int         cyc      = 0;
    int         vectors  = 0;
    int         fails    = 0;
    logic       prev_en  = 1'b0;
    logic [1:0] prev_sel = 2'b00;
    int         low_cnt  = 0;
    logic [1:0] cur_sel;
    int         c;
    int         h;

    uart_sol_ctrl #(
        .DEBOUNCE_CYC (4),
        .IDLE_CYC     (8),
        .GAP_CYC      (2),
        .TIMEOUT_CYC  (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bmc_gpio24    (bmc_gpio24),
        .bmc_gpio25    (bmc_gpio25),
        .bmc_tx        (bmc_tx),
        .host_tx       (host_tx),
        .sol_select    (sol_select),
        .sol_en        (sol_en),
        .switch_busy   (switch_busy),
        .switch_done   (switch_done),
        .switch_forced (switch_forced)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [1:0] sel, input int at);
        exp_t e;
        e.kind = kind;
        e.sel  = sel;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic see(input int kind);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL event: unexpected kind %0d at cycle %0d sel %b", kind, cyc, sol_select);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.sel != sol_select ||
                (kind == EV_DONE && low_cnt != LOW_EXP)) begin
                fails++;
                $display("FAIL event: got kind %0d cycle %0d sel %b low %0d, expected kind %0d cycle %0d sel %b low %0d",
                         kind, cyc, sol_select, low_cnt, e.kind, e.cyc, e.sel, LOW_EXP);
            end
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge and matches observed events.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            prev_en  = 1'b0;
            prev_sel = sol_select;
            low_cnt  = 0;
        end else begin
            if (prev_en && !sol_en) see(EV_FALL);
            if (switch_forced) see(EV_FORCED);
            if (switch_done) see(EV_DONE);
            if (sol_select != prev_sel) begin
                vectors++;
                if (prev_en || sol_en) begin
                    fails++;
                    $display("FAIL sel_while_enabled: sel %b -> %b with en %b/%b at cycle %0d",
                             prev_sel, sol_select, prev_en, sol_en, cyc);
                end
            end
            if (!sol_en) low_cnt = low_cnt + 1;
            else low_cnt = 0;
            prev_en  = sol_en;
            prev_sel = sol_select;
        end
    end

    task automatic set_gpio(input logic [1:0] v);
        bmc_gpio24 = v[1];
        bmc_gpio25 = v[0];
    endtask

    task automatic go_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        bmc_tx  = 1'b1;
        host_tx = 1'b1;
        set_gpio(2'b00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sel", 32'(sol_select), 32'h0);
        chk("rst_en", 32'(sol_en), 32'h0);
        chk("rst_busy", 32'(switch_busy), 32'h1);
        chk("rst_done", 32'(switch_done), 32'h0);
        chk("rst_forced", 32'(switch_forced), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_sel", 32'(sol_select), 32'h0);
        chk("post_rst_en", 32'(sol_en), 32'h1);
        chk("post_rst_busy", 32'(switch_busy), 32'h0);
        chk("post_rst_done", 32'(switch_done), 32'h0);

        // Bounce: 11 held only two cycles, never accepted.
        c = cyc;
        set_gpio(2'b11);
        go_to(c + 2);
        set_gpio(2'b00);
        go_to(c + 20);
        chk("bounce_en", 32'(sol_en), 32'h1);
        chk("bounce_busy", 32'(switch_busy), 32'h0);
        chk("bounce_sel", 32'(sol_select), 32'h0);

        // Abort: request 01 with BMC TX busy, then revert to 00 during WAIT_IDLE.
        c = cyc;
        bmc_tx = 1'b0;
        set_gpio(2'b01);
        go_to(c + 8);
        chk("abort_wait_busy", 32'(switch_busy), 32'h1);
        set_gpio(2'b00);
        go_to(c + 12);
        chk("abort_wait_en", 32'(sol_en), 32'h1);
        chk("abort_wait_busy2", 32'(switch_busy), 32'h1);
        go_to(c + 20);
        chk("abort_busy", 32'(switch_busy), 32'h0);
        chk("abort_sel", 32'(sol_select), 32'h0);
        chk("abort_en", 32'(sol_en), 32'h1);
        bmc_tx = 1'b1;

        // Idle switch 00 -> 10: deb at +6, WAIT at +7, GAP at +15, done at +18.
        c = cyc;
        push(EV_FALL, 2'b00, c + 15);
        push(EV_DONE, 2'b10, c + 18);
        set_gpio(2'b10);
        go_to(c + 16);
        chk("idle_gap_en", 32'(sol_en), 32'h0);
        chk("idle_gap_busy", 32'(switch_busy), 32'h1);
        go_to(c + 25);
        chk("idle_sel", 32'(sol_select), 32'h2);
        chk("idle_en", 32'(sol_en), 32'h1);
        chk("idle_busy", 32'(switch_busy), 32'h0);

        // Busy host line: one low cycle in every five, then held high.
        c = cyc;
        set_gpio(2'b01);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            host_tx = (k % 5 == 0) ? 1'b0 : 1'b1;
            if (k == 20) begin
                chk("busy_line_en", 32'(sol_en), 32'h1);
                chk("busy_line_busy", 32'(switch_busy), 32'h1);
            end
        end
        @(negedge clk);
        host_tx = 1'b1;
        h = cyc;
        push(EV_FALL, 2'b10, h + 10);
        push(EV_DONE, 2'b01, h + 13);
        go_to(h + 20);
        chk("busy_sel", 32'(sol_select), 32'h1);
        cur_sel = 2'b01;

`ifdef UART_SOL_CTRL_TIMEOUT_EN
        // Forced switch: WAIT entry at +7, timeout 32 cycles later at +39.
        c = cyc;
        bmc_tx = 1'b0;
        set_gpio(2'b11);
        push(EV_FALL, 2'b01, c + 39);
        push(EV_FORCED, 2'b01, c + 39);
        push(EV_DONE, 2'b11, c + 42);
        go_to(c + 30);
        chk("forced_wait_en", 32'(sol_en), 32'h1);
        chk("forced_wait_busy", 32'(switch_busy), 32'h1);
        go_to(c + 50);
        chk("forced_sel", 32'(sol_select), 32'h3);
        bmc_tx = 1'b1;
        cur_sel = 2'b11;
`endif

        // Reset asserted while in GAP.
        c = cyc;
        push(EV_FALL, cur_sel, c + 15);
        set_gpio(2'b10);
        go_to(c + 15);
        chk("gap_en", 32'(sol_en), 32'h0);
        chk("gap_sel", 32'(sol_select), 32'(cur_sel));
        reset = 1'b1;
        set_gpio(2'b00);
        @(negedge clk);
        chk("gap_rst_sel", 32'(sol_select), 32'h0);
        chk("gap_rst_en", 32'(sol_en), 32'h0);
        chk("gap_rst_busy", 32'(switch_busy), 32'h1);
        chk("gap_rst_done", 32'(switch_done), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("gap_post_en", 32'(sol_en), 32'h1);
        chk("gap_post_sel", 32'(sol_select), 32'h0);
        repeat (15) @(negedge clk);
        chk("final_en", 32'(sol_en), 32'h1);
        chk("final_busy", 32'(switch_busy), 32'h0);

        vectors++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_events: %0d expected events never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
